// File: rtl/pll_reconf_sequencer_pkg.sv
// Shared types and constants for the PLL DRP reconfiguration sequencer:
// FSM state encoding, ROM entry layout and fixed timing lengths.
package pll_reconf_sequencer_pkg;

  localparam int NUM_REGS      = 23;
  localparam int STAB_CYCLES   = 8;
  localparam int SETTLE_CYCLES = 16;
  localparam int OPT_W         = 3;
  localparam int IDX_W         = 5;
  localparam int ADDR_W        = 5;
  localparam int DATA_W        = 16;

  typedef enum logic [3:0] {
    IDLE,
    ASSERT_RST,
    RD,
    RD_WAIT,
    WR,
    WR_WAIT,
    NEXT,
    RELEASE,
    SETTLE,
    LOCK_WAIT,
    DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] value;
  } rom_entry_t;

  // A mask bit of 1 keeps the bit read back from the DRP register.
  function automatic logic [DATA_W-1:0] merge_bits(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] mask,
                                                   input logic [DATA_W-1:0] value);
    return (cur & mask) | (value & ~mask);
  endfunction

endpackage

// File: rtl/pll_reconf_rom.sv
// Configuration ROM: one {addr, mask, value} entry per {option, register index}.
// Purely combinational so the sequencer can look one index ahead.
module pll_reconf_rom
  import pll_reconf_sequencer_pkg::*;
(
  input  logic [7:0]  sel_i,
  output logic [4:0]  addr_o,
  output logic [15:0] mask_o,
  output logic [15:0] value_o
);

  logic [2:0] opt;
  logic [4:0] idx;
  rom_entry_t entry;

  assign opt = sel_i[7:5];
  assign idx = sel_i[4:0];

  // Content: addr = idx + 3*opt, a rotating nibble keep-mask, value = 0x1234 + 0x101*opt + 0x11*idx.
  always_comb begin
    entry.addr  = idx + {1'b0, opt, 1'b0} + {2'b00, opt};
    entry.mask  = 16'h00F0 << {idx[1:0], 2'b00};
    entry.value = 16'h1234 + {5'd0, opt, 5'd0, opt} + {7'd0, idx, 4'd0} + {11'd0, idx};
  end

  assign addr_o  = entry.addr;
  assign mask_o  = entry.mask;
  assign value_o = entry.value;

endmodule

// File: rtl/pll_reconf_sequencer.sv
// Rewrites NUM_REGS PLL DRP registers by read-modify-write whenever a new,
// stable configuration option is requested, then waits for the PLL to relock.
module pll_reconf_sequencer #(
  parameter int NUM_REGS     = pll_reconf_sequencer_pkg::NUM_REGS,
  parameter int DRDY_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  pll_option,
  output logic [4:0]  daddr,
  output logic [15:0] di,
  input  logic [15:0] dout,
  output logic        den,
  output logic        dwe,
  input  logic        drdy,
  input  logic        locked,
  output logic        pll_rst,
  output logic        busy,
  output logic        srdy,
  output logic        err
);

  import pll_reconf_sequencer_pkg::*;

  localparam int               TMO_W       = $clog2(DRDY_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(DRDY_TIMEOUT - 1);
  localparam logic [4:0]       IDX_LAST    = 5'(NUM_REGS - 1);
  localparam logic [3:0]       STAB_LAST   = 4'(STAB_CYCLES);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e            state_q;
  logic              lock_meta_q, lock_sync_q;
  logic [2:0]        opt_prev_q;
  logic [3:0]        stab_cnt_q;
  logic              stab_done;
  logic              pending_q;
  logic              fail_q;
  logic [2:0]        applied_q;
  logic [2:0]        cur_opt_q;
  logic [4:0]        idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q;
  logic [3:0]        settle_q;
  logic [4:0]        daddr_q;
  logic [15:0]       di_q;
  logic              den_q, dwe_q, pll_rst_q, busy_q, srdy_q, err_q;
  logic [4:0]        rom_addr;
  logic [15:0]       rom_mask, rom_value;

  // NOTE: every register here uses a synchronous reset inside always_ff with
  // non-blocking assignments, so all state updates happen together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opt_prev_q <= '0;
      stab_cnt_q <= '0;
    end else begin
      opt_prev_q <= pll_option;
      if (pll_option != opt_prev_q) begin
        stab_cnt_q <= '0;
      end else if (stab_cnt_q != STAB_LAST) begin
        stab_cnt_q <= stab_cnt_q + 4'd1;
      end
    end
  end

  // Also require no change this cycle, so the option latched on start is the stable one.
  assign stab_done = (stab_cnt_q == STAB_LAST) && (pll_option == opt_prev_q);

  // Look-ahead index lets the combinational ROM present the entry the next RD needs.
  always_comb begin
    idx_d = idx_q;
    if (state_q == ASSERT_RST) begin
      idx_d = '0;
    end else if (state_q == NEXT) begin
      idx_d = idx_q + 5'd1;
    end
  end

  pll_reconf_rom u_rom (
    .sel_i   ({cur_opt_q, idx_d}),
    .addr_o  (rom_addr),
    .mask_o  (rom_mask),
    .value_o (rom_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b1;
      fail_q    <= 1'b0;
      applied_q <= '0;
      cur_opt_q <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      settle_q  <= '0;
      daddr_q   <= '0;
      di_q      <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      pll_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      srdy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      den_q  <= 1'b0;
      dwe_q  <= 1'b0;
      srdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (stab_done && (pending_q || (pll_option != applied_q))) begin
            cur_opt_q <= pll_option;
            fail_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ASSERT_RST;
          end
        end
        ASSERT_RST: begin
          idx_q   <= idx_d;
          daddr_q <= rom_addr;
          den_q   <= 1'b1;
          state_q <= RD;
        end
        RD: begin
          tmo_q   <= TMO_W'(1);
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (drdy) begin
            // The read data is captured directly into the merged write word.
            di_q    <= merge_bits(dout, rom_mask, rom_value);
            den_q   <= 1'b1;
            dwe_q   <= 1'b1;
            state_q <= WR;
          end else if (tmo_q >= TMO_LAST) begin
            err_q     <= 1'b1;
            fail_q    <= 1'b1;
            pending_q <= 1'b1;
            pll_rst_q <= 1'b0;
            state_q   <= RELEASE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        WR: begin
          tmo_q   <= TMO_W'(1);
          state_q <= WR_WAIT;
        end
        WR_WAIT: begin
          if (drdy) begin
            state_q <= NEXT;
          end else if (tmo_q >= TMO_LAST) begin
            err_q     <= 1'b1;
            fail_q    <= 1'b1;
            pending_q <= 1'b1;
            pll_rst_q <= 1'b0;
            state_q   <= RELEASE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        NEXT: begin
          if (idx_q == IDX_LAST) begin
            pll_rst_q <= 1'b0;
            state_q   <= RELEASE;
          end else begin
            idx_q   <= idx_d;
            daddr_q <= rom_addr;
            den_q   <= 1'b1;
            state_q <= RD;
          end
        end
        RELEASE: begin
          settle_q <= '0;
          state_q  <= SETTLE;
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= LOCK_WAIT;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        LOCK_WAIT: begin
          if (lock_sync_q) begin
            srdy_q  <= ~fail_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          // A timed-out pass leaves pending set so IDLE retries it.
          if (!fail_q) begin
            applied_q <= cur_opt_q;
            pending_q <= 1'b0;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign daddr   = daddr_q;
  assign di      = di_q;
  assign den     = den_q;
  assign dwe     = dwe_q;
  assign pll_rst = pll_rst_q;
  assign busy    = busy_q;
  assign srdy    = srdy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_pll_reconf_sequencer.sv
// Directed-plus-random bench: a DRP slave and PLL model log every transaction,
// and each completed sequence is compared against a behavioural ROM/RMW model.
module tb_pll_reconf_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  pll_option = 3'd3;
  logic [4:0]  daddr;
  logic [15:0] di;
  logic [15:0] dout = '0;
  logic        den, dwe;
  logic        drdy = 1'b0;
  logic        locked = 1'b0;
  logic        pll_rst, busy, srdy, err;

  pll_reconf_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .pll_option (pll_option),
    .daddr      (daddr),
    .di         (di),
    .dout       (dout),
    .den        (den),
    .dwe        (dwe),
    .drdy       (drdy),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .busy       (busy),
    .srdy       (srdy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] data;
    logic        prst;
    logic        bsy;
    logic        stable;
  } txn_t;

  txn_t txq[$];
  int   n_pass = 0, n_fail = 0, n_total = 0;
  int   drp_lat = 2, lock_delay = 10, lock_cnt = 0;
  bit   drp_hold = 1'b0, dout_ffff = 1'b0;
  int   pend = 0, cur = 0, srdy_cnt = 0, proto_err = 0;
  bit   outstanding = 1'b0, den_prev = 1'b0, srdy_prev = 1'b0;

  // ---------------- behavioural reference model ----------------
  function automatic logic [4:0] m_addr(input int opt, input int idx);
    return 5'((idx + 3 * opt) % 32);
  endfunction

  function automatic logic [15:0] m_mask(input int idx);
    logic [15:0] m = 16'h00F0;
    return m << (4 * (idx % 4));
  endfunction

  function automatic logic [15:0] m_val(input int opt, input int idx);
    return 16'((32'h1234 + opt * 257 + idx * 17) % 65536);
  endfunction

  function automatic logic [15:0] m_merge(input logic [15:0] rd, input logic [15:0] mask,
                                          input logic [15:0] val);
    logic [15:0] r;
    for (int b = 0; b < 16; b++) r[b] = mask[b] ? rd[b] : val[b];
    return r;
  endfunction

  // ---------------- DRP slave, PLL and protocol monitor ----------------
  always @(negedge clk) begin
    txn_t t;
    drdy = 1'b0;
    if (rst || !busy) outstanding = 1'b0;
    if (pend > 0) begin
      t = txq[cur];
      if (daddr !== t.addr || (t.we && di !== t.data)) t.stable = 1'b0;
      pend--;
      if (pend == 0) begin
        drdy = 1'b1;
        outstanding = 1'b0;
        if (!t.we) begin
          dout   = dout_ffff ? 16'hFFFF : 16'($urandom);
          t.data = dout;
        end
      end
      txq[cur] = t;
    end
    if (dwe && !den) proto_err++;
    if (den && (den_prev || outstanding)) proto_err++;
    if (den) begin
      t.we = dwe; t.addr = daddr; t.data = di;
      t.prst = pll_rst; t.bsy = busy; t.stable = 1'b1;
      txq.push_back(t);
      cur = txq.size() - 1;
      outstanding = 1'b1;
      if (!drp_hold) pend = drp_lat;
    end
    den_prev = den;
    if (srdy) begin
      if (srdy_prev) proto_err++;
      srdy_cnt++;
    end
    srdy_prev = srdy;
    if (pll_rst) begin
      locked = 1'b0;
      lock_cnt = 0;
    end else if (lock_cnt < lock_delay) begin
      lock_cnt++;
    end else begin
      locked = 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_srdy(input int target, input int budget, input string tag);
    int n = 0;
    while (srdy_cnt < target && n < budget) begin
      cycles(1);
      n++;
    end
    check({tag, " srdy reached"}, 32'(srdy_cnt >= target), 1);
  endtask

  function automatic int reads_since(input int base);
    int c = 0;
    for (int k = base; k < txq.size(); k++) if (!txq[k].we) c++;
    return c;
  endfunction

  task automatic check_seq(input int opt, input int base, input string tag);
    txn_t rd, wr;
    check({tag, " txn count"}, 32'(txq.size() - base), 32'(2 * 23));
    if (txq.size() - base < 2 * 23) return;
    for (int i = 0; i < 23; i++) begin
      rd = txq[base + 2 * i];
      wr = txq[base + 2 * i + 1];
      check($sformatf("%s[%0d] rd addr", tag, i), {rd.we, rd.addr}, {1'b0, m_addr(opt, i)});
      check($sformatf("%s[%0d] wr addr", tag, i), {wr.we, wr.addr}, {1'b1, m_addr(opt, i)});
      check($sformatf("%s[%0d] wr data", tag, i), wr.data,
            m_merge(rd.data, m_mask(i), m_val(opt, i)));
      check($sformatf("%s[%0d] env", tag, i),
            {rd.prst, wr.prst, rd.bsy, wr.bsy, rd.stable, wr.stable}, 6'b111111);
    end
  endtask

  // ---------------- directed sequence ----------------
  int  exp_srdy = 0;
  int  base, n, opt, cur_opt;
  bit  busy_seen;

  initial begin
    // Reset values
    cycles(3);
    check("reset ctrl", {den, dwe, pll_rst, srdy, err, busy}, 6'b0);
    check("reset daddr", daddr, 5'd0);
    check("reset di", di, 16'd0);

    // Boot: forced first configuration of option 3, drdy after 2 cycles
    rst = 1'b0;
    base = txq.size();
    exp_srdy++;
    wait_srdy(exp_srdy, 2000, "boot");
    check_seq(3, base, "boot");
    cycles(3);
    check("boot srdy pulses", srdy_cnt, exp_srdy);
    check("boot idle", {busy, err, pll_rst}, 3'b000);
    cur_opt = 3;

    // Glitch 3->5->3 while 3 is applied: nothing may start
    base = txq.size();
    busy_seen = 1'b0;
    pll_option = 3'd5;
    cycles(2);
    pll_option = 3'd3;
    for (int k = 0; k < 40; k++) begin
      cycles(1);
      busy_seen |= busy;
    end
    check("glitch no busy", busy_seen, 1'b0);
    check("glitch no txn", 32'(txq.size() - base), 0);

    // Read-modify-write with all-ones read data
    dout_ffff = 1'b1;
    drp_lat = $urandom_range(1, 4);
    base = txq.size();
    pll_option = 3'd0;
    exp_srdy++;
    wait_srdy(exp_srdy, 2000, "rmw");
    check_seq(0, base, "rmw");
    check("rmw first di", (txq.size() > base + 1) ? txq[base + 1].data : 16'h0, 16'h12F4);
    dout_ffff = 1'b0;
    cur_opt = 0;

    // Random option changes, latencies and lock times
    for (int k = 0; k < 3; k++) begin
      do opt = $urandom_range(0, 7); while (opt == cur_opt || opt == 2 || opt == 6);
      drp_lat = $urandom_range(1, 4);
      lock_delay = $urandom_range(3, 30);
      base = txq.size();
      pll_option = 3'(opt);
      exp_srdy++;
      wait_srdy(exp_srdy, 2000, $sformatf("rand%0d", k));
      check_seq(opt, base, $sformatf("rand%0d", k));
      cur_opt = opt;
    end

    // Option changes to 6 during register 10 of option 2
    drp_lat = $urandom_range(1, 4);
    base = txq.size();
    pll_option = 3'd2;
    n = 0;
    while (reads_since(base) < 11 && n < 2000) begin
      cycles(1);
      n++;
    end
    check("mid reached reg10", 32'(reads_since(base) >= 11), 1);
    pll_option = 3'd6;
    exp_srdy++;
    wait_srdy(exp_srdy, 2000, "mid opt2");
    check_seq(2, base, "mid opt2");
    exp_srdy++;
    wait_srdy(exp_srdy, 2000, "mid opt6");
    check_seq(6, base + 2 * 23, "mid opt6");
    check("mid err clear", err, 1'b0);

    // drdy withheld: timeout, release and retry
    drp_hold = 1'b1;
    pll_option = 3'd1;
    n = 0;
    while (!den && n < 200) begin
      cycles(1);
      n++;
    end
    check("tmo den seen", den, 1'b1);
    n = 0;
    while (!err && n < 400) begin
      cycles(1);
      n++;
    end
    check("tmo cycles to err", n, 255);
    check("tmo pll_rst released", pll_rst, 1'b0);
    check("tmo busy", busy, 1'b1);
    drp_hold = 1'b0;
    base = txq.size();
    exp_srdy++;
    wait_srdy(exp_srdy, 3000, "retry");
    check_seq(1, base, "retry");
    check("retry err sticky", err, 1'b1);

    // Reset while waiting for a write to complete
    drp_lat = 4;
    pll_option = 3'd4;
    n = 0;
    while (!dwe && n < 500) begin
      cycles(1);
      n++;
    end
    check("rst saw write", dwe, 1'b1);
    cycles(1);
    rst = 1'b1;
    cycles(1);
    check("rst abort outputs", {den, dwe, pll_rst, busy, err}, 5'b0);
    rst = 1'b0;
    base = txq.size();
    exp_srdy++;
    wait_srdy(exp_srdy, 3000, "rerun");
    check_seq(4, base, "rerun");

    cycles(5);
    check("protocol violations", proto_err, 0);
    check("total srdy pulses", srdy_cnt, exp_srdy);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pll_reconf_sequencer.md
PLL_RECONF_SEQUENCER -- requirements
Module: pll_reconf_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 23, meaning the number of DRP registers rewritten per configuration.
REQ-002 SHALL have parameter DRDY_TIMEOUT, default 255, meaning the maximum number of cycles to wait for drdy after a den pulse.
REQ-003 SHALL have ports:
- clk, in, 1: single clock for all logic; also the DRP clock.
- rst, in, 1: synchronous, active-high reset.
- pll_option, in, 3: requested PLL configuration index, 0..7.
- daddr, out, 5: DRP address.
- di, out, 16: DRP write data.
- dout, in, 16: DRP read data.
- den, out, 1: DRP enable pulse.
- dwe, out, 1: DRP write enable.
- drdy, in, 1: DRP ready.
- locked, in, 1: PLL lock, asynchronous.
- pll_rst, out, 1: PLL reset.
- busy, out, 1: reconfiguration in progress.
- srdy, out, 1: one-cycle pulse when the PLL is relocked.
- err, out, 1: sticky DRP timeout flag.

Function
REQ-004 SHALL synchronise locked through two flops before any use.
REQ-005 SHALL restart an 8-cycle stability counter whenever pll_option differs from its previous-cycle value.
REQ-006 SHALL start a sequence in IDLE when the counter expires and either pending=1 or pll_option differs from the last applied option.
- On start, pll_option SHALL be latched into cur_opt.
REQ-007 SHALL use states IDLE, ASSERT_RST, RD, RD_WAIT, WR, WR_WAIT, NEXT, RELEASE, SETTLE, LOCK_WAIT, DONE.
REQ-008 ASSERT_RST SHALL assert pll_rst and clear the register index to 0; pll_rst SHALL stay high until RELEASE.
REQ-009 RD SHALL drive a one-cycle den with dwe=0 and daddr = ROM addr[cur_opt][idx].
REQ-010 RD_WAIT SHALL hold until drdy=1, then capture dout.
REQ-011 WR SHALL drive a one-cycle den and dwe with di = (captured & mask) | (value & ~mask).
- mask bit 1 means keep the existing bit.
REQ-012 WR_WAIT SHALL hold until drdy=1.
REQ-013 NEXT SHALL increment idx; idx = NUM_REGS-1 SHALL go to RELEASE, otherwise to RD.
REQ-014 RELEASE SHALL deassert pll_rst.
- SETTLE SHALL wait 16 cycles.
- LOCK_WAIT SHALL wait for synchronised locked=1.
REQ-015 DONE SHALL pulse srdy for exactly one cycle, record cur_opt as the applied option, clear pending, and return to IDLE.
REQ-016 At most one DRP transaction SHALL be outstanding.
- daddr and di SHALL be stable from den until drdy.
- A drdy in any state other than RD_WAIT or WR_WAIT SHALL be ignored.
REQ-017 If drdy has not arrived DRDY_TIMEOUT cycles after den:
- err SHALL be set.
- The sequence SHALL jump to RELEASE.
- Pending SHALL stay set so that the sequence retries.
REQ-018 A pll_option change while busy SHALL NOT affect cur_opt.
- It SHALL be handled after DONE through the REQ-006 comparison.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 den and dwe SHALL never be high outside RD and WR.

Reset
REQ-021 On rst the outputs SHALL be:
- den=0, dwe=0, daddr=0, di=0.
- pll_rst=0, srdy=0, err=0, busy=0.
REQ-022 On rst the internal state SHALL be: state=IDLE, pending=1, applied option=0, stability counter cleared.
- The first configuration is therefore forced after boot.
REQ-023 A reset mid-sequence SHALL abandon the transaction, deassert pll_rst and restart from IDLE with pending=1.

Structure
REQ-024 A shared package SHALL hold:
- The state enumeration.
- The ROM entry layout: addr 5, mask 16, value 16.
- The constants NUM_REGS, the 8-cycle stability length and the 16-cycle SETTLE length.
REQ-025 The ROM SHALL be a sub-module pll_reconf_rom.
- It SHALL be indexed by {option, idx}.
- It SHALL be combinational or registered, with the sequencer absorbing one cycle of latency.

Verification
REQ-026 Boot: rst released, pll_option=3, DRP model with drdy after 2 cycles -> exactly 23 reads and 23 writes to ROM option 3 addresses; pll_rst high throughout; locked raised -> srdy single pulse.
REQ-027 Read-modify-write: dout=0xFFFF, mask=0x00F0, value=0x1234 -> di=0x12F4.
REQ-028 Glitch: pll_option toggles 3->5->3 within 5 cycles while option 3 is applied -> no sequence starts.
REQ-029 Mid-sequence change: pll_option changes to 6 during register 10 of option 2 -> option 2 completes with srdy -> option 6 sequence follows automatically.
REQ-030 Timeout: drdy withheld -> err=1 at cycle 255 after den, pll_rst released, retry sequence starts.
REQ-031 Reset during WR_WAIT -> den=0 and pll_rst=0 in the next cycle -> full sequence reruns.
